// File: rtl/ddr_pkg.sv
// Shared definitions for the simulated-DDR initiator.
// Contents: FSM state encodings, interface widths, nominal memory latencies,
// and the byte-address to word-index helper used for both request ports.
package ddr_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam int DDR_ADDR_W  = 19;
  localparam int DDR_BURST_W = 512;
  localparam int DDR_WORD_W  = 64;
  localparam int SINGLE_LAT  = 64;
  localparam int BURST_LAT   = 80;

  // Memory is indexed in 64-bit words; drop the byte offset and keep 19 bits.
  function automatic logic [DDR_ADDR_W-1:0] word_index(input logic [63:0] byte_addr,
                                                       input int lsb);
    logic [63:0] shifted;
    shifted = byte_addr >> lsb;
    return shifted[DDR_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/ddr_rr_arb.sv
// Two-requester round-robin grant (fetch vs LSU).
// Ports:
//   clk, rst             clock, async active-high reset
//   open                 arbitration allowed this cycle
//   req_fetch, req_lsu   qualified requests
//   grant_fetch/lsu      one-hot (or zero) combinational grant
// rr_last records the last winner: 0 = fetch, 1 = LSU. On a tie the
// requester that did not win last time is granted.
module ddr_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic open,
  input  logic req_fetch,
  input  logic req_lsu,
  output logic grant_fetch,
  output logic grant_lsu
);

  logic rr_last;

  always_comb begin
    grant_fetch = 1'b0;
    grant_lsu   = 1'b0;
    if (open) begin
      if (req_fetch && req_lsu) begin
        grant_fetch = rr_last;
        grant_lsu   = ~rr_last;
      end else begin
        grant_fetch = req_fetch;
        grant_lsu   = req_lsu;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= 1'b0;
    end else if (grant_fetch) begin
      rr_last <= 1'b0;
    end else if (grant_lsu) begin
      rr_last <= 1'b1;
    end
  end

endmodule

// File: rtl/ddr_arbiter.sv
// Initiator side of the simulated-DDR interface. Arbitrates between the
// frontend fetch port (512-bit burst read) and the LSU port (64-bit read or
// masked write), holds one transaction stable on the memory interface and
// returns single-cycle response pulses.
// Ports:
//   clk, rst                         clock, async active-high reset
//   fetch_req_* / fetch_flush        fetch request port and flush
//   fetch_resp_valid/data            fetch response (one-cycle pulse)
//   lsu_req_*                        LSU request port
//   lsu_resp_valid/data              LSU response (data 0 on write ack)
//   chip_enable .. sw_write_data     memory command outputs
//   fetch_burst_read_inst, lw_read_data, ddr_operation_done  memory returns
//   ddr_timeout_err                  sticky timeout flag
//
// state   | meaning
// IDLE    | no transaction, arbitration open
// BUSY    | command held on memory interface until ddr_operation_done
// RESP    | response pulse to owner; arbitration also open here
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter int ADDR_LSB = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req_valid,
  output logic                   fetch_req_ready,
  input  logic [63:0]            fetch_req_addr,
  input  logic                   fetch_flush,
  output logic                   fetch_resp_valid,
  output logic [DDR_BURST_W-1:0] fetch_resp_data,
  input  logic                   lsu_req_valid,
  output logic                   lsu_req_ready,
  input  logic                   lsu_req_we,
  input  logic [63:0]            lsu_req_addr,
  input  logic [DDR_WORD_W-1:0]  lsu_req_wdata,
  input  logic [DDR_WORD_W-1:0]  lsu_req_wmask,
  output logic                   lsu_resp_valid,
  output logic [DDR_WORD_W-1:0]  lsu_resp_data,
  output logic                   chip_enable,
  output logic                   write_enable,
  output logic                   burst_mode,
  output logic [DDR_ADDR_W-1:0]  address,
  output logic [DDR_WORD_W-1:0]  sw_write_mask,
  output logic [DDR_WORD_W-1:0]  sw_write_data,
  input  logic [DDR_BURST_W-1:0] fetch_burst_read_inst,
  input  logic [DDR_WORD_W-1:0]  lw_read_data,
  input  logic                   ddr_operation_done,
  output logic                   ddr_timeout_err
);

  localparam int           CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);

  state_t           state;
  logic             owner_lsu;
  logic             flush_pending;
  logic [CNT_W-1:0] tmo_cnt;
  logic             arb_open;
  logic             grant_fetch;
  logic             grant_lsu;
  logic [63:0]      fetch_line;
  logic             unused_line_offset;

  // Fetch is always a whole 64-byte line.
  assign fetch_line         = {fetch_req_addr[63:6], 6'b0};
  assign unused_line_offset = ^fetch_req_addr[5:0];

  // RESP also arbitrates so a waiting request starts in the cycle after RESP.
  assign arb_open = (state == ST_IDLE) || (state == ST_RESP);

  ddr_rr_arb u_rr_arb (
    .clk         (clk),
    .rst         (rst),
    .open        (arb_open),
    .req_fetch   (fetch_req_valid & ~fetch_flush),
    .req_lsu     (lsu_req_valid),
    .grant_fetch (grant_fetch),
    .grant_lsu   (grant_lsu)
  );

  assign fetch_req_ready = grant_fetch;
  assign lsu_req_ready   = grant_lsu;

  // Dropping enable in the completion cycle keeps the memory from seeing a
  // second request while it returns to idle.
  assign chip_enable = (state == ST_BUSY) & ~ddr_operation_done;

  assign fetch_resp_valid = (state == ST_RESP) & ~owner_lsu & ~flush_pending & ~fetch_flush;
  assign lsu_resp_valid   = (state == ST_RESP) & owner_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      owner_lsu       <= 1'b0;
      write_enable    <= 1'b0;
      burst_mode      <= 1'b0;
      address         <= '0;
      sw_write_mask   <= '0;
      sw_write_data   <= '0;
      flush_pending   <= 1'b0;
      tmo_cnt         <= '0;
      ddr_timeout_err <= 1'b0;
      fetch_resp_data <= '0;
      lsu_resp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          flush_pending <= 1'b0;
          if (grant_fetch || grant_lsu) begin
            state         <= ST_BUSY;
            owner_lsu     <= grant_lsu;
            write_enable  <= grant_lsu & lsu_req_we;
            burst_mode    <= grant_fetch;
            address       <= grant_fetch ? word_index(fetch_line, ADDR_LSB)
                                         : word_index(lsu_req_addr, ADDR_LSB);
            sw_write_mask <= grant_lsu ? lsu_req_wmask : '0;
            sw_write_data <= grant_lsu ? lsu_req_wdata : '0;
            tmo_cnt       <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // The memory op is never aborted; a flush only hides its response.
          if (fetch_flush && !owner_lsu) begin
            flush_pending <= 1'b1;
          end
          if (ddr_operation_done) begin
            state <= ST_RESP;
            if (owner_lsu) begin
              lsu_resp_data <= write_enable ? '0 : lw_read_data;
            end else begin
              fetch_resp_data <= fetch_burst_read_inst;
            end
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (tmo_cnt == TMO_MAX - CNT_W'(1)) begin
              ddr_timeout_err <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_arbiter.sv
module tb_ddr_arbiter;
  import ddr_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_req_valid, fetch_req_ready, fetch_flush, fetch_resp_valid;
  logic [63:0]  fetch_req_addr;
  logic [511:0] fetch_resp_data, fetch_burst_read_inst;
  logic         lsu_req_valid, lsu_req_ready, lsu_req_we, lsu_resp_valid;
  logic [63:0]  lsu_req_addr, lsu_req_wdata, lsu_req_wmask, lsu_resp_data;
  logic         chip_enable, write_enable, burst_mode, ddr_operation_done, ddr_timeout_err;
  logic [18:0]  address;
  logic [63:0]  sw_write_mask, sw_write_data, lw_read_data;

  // second instance: short timeout, memory that never completes
  logic         t_rst, t_lsu_valid;
  logic         t_fetch_ready, t_fetch_resp_valid, t_lsu_ready, t_lsu_resp_valid;
  logic         t_ce, t_we, t_bm, t_err;
  logic [511:0] t_fetch_resp_data;
  logic [63:0]  t_lsu_resp_data, t_mask, t_data;
  logic [18:0]  t_addr;
  logic         unused_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_arbiter #(.TIMEOUT(255), .ADDR_LSB(3)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_addr(fetch_req_addr), .fetch_flush(fetch_flush),
    .fetch_resp_valid(fetch_resp_valid), .fetch_resp_data(fetch_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .chip_enable(chip_enable), .write_enable(write_enable), .burst_mode(burst_mode),
    .address(address), .sw_write_mask(sw_write_mask), .sw_write_data(sw_write_data),
    .fetch_burst_read_inst(fetch_burst_read_inst), .lw_read_data(lw_read_data),
    .ddr_operation_done(ddr_operation_done), .ddr_timeout_err(ddr_timeout_err)
  );

  ddr_arbiter #(.TIMEOUT(10), .ADDR_LSB(3)) u_to (
    .clk(clk), .rst(t_rst),
    .fetch_req_valid(1'b0), .fetch_req_ready(t_fetch_ready),
    .fetch_req_addr(64'h0), .fetch_flush(1'b0),
    .fetch_resp_valid(t_fetch_resp_valid), .fetch_resp_data(t_fetch_resp_data),
    .lsu_req_valid(t_lsu_valid), .lsu_req_ready(t_lsu_ready), .lsu_req_we(1'b0),
    .lsu_req_addr(64'h8000_0040), .lsu_req_wdata(64'h0), .lsu_req_wmask(64'h0),
    .lsu_resp_valid(t_lsu_resp_valid), .lsu_resp_data(t_lsu_resp_data),
    .chip_enable(t_ce), .write_enable(t_we), .burst_mode(t_bm),
    .address(t_addr), .sw_write_mask(t_mask), .sw_write_data(t_data),
    .fetch_burst_read_inst(512'h0), .lw_read_data(64'h0),
    .ddr_operation_done(1'b0), .ddr_timeout_err(t_err)
  );

  assign unused_t = ^{t_fetch_ready, t_fetch_resp_valid, t_lsu_resp_valid, t_we, t_bm,
                      t_fetch_resp_data, t_lsu_resp_data, t_mask, t_data, t_addr};

  // Memory stub: done one cycle after SINGLE_LAT+1 / BURST_LAT+1 enabled cycles.
  function automatic logic [63:0] init_word(input int i);
    if (i == 8) return 64'h1234;
    if (i > 8 && i < 16) return 64'hC0DE_0000_0000_0000 | 64'(i);
    return 64'h0;
  endfunction

  logic [63:0] mem [0:63];
  int en_run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_run <= 0;
      ddr_operation_done <= 1'b0;
      lw_read_data <= '0;
      fetch_burst_read_inst <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (ddr_operation_done) begin
      ddr_operation_done <= 1'b0;
      en_run <= 0;
    end else if (chip_enable) begin
      en_run <= en_run + 1;
      if (en_run + 1 == (burst_mode ? BURST_LAT : SINGLE_LAT) + 1) begin
        ddr_operation_done <= 1'b1;
        if (burst_mode) begin
          for (int i = 0; i < 8; i++)
            fetch_burst_read_inst[i*64 +: 64] <= mem[{address[5:3], 3'(i)}];
        end else if (write_enable) begin
          mem[address[5:0]] <= (mem[address[5:0]] & ~sw_write_mask) | (sw_write_data & sw_write_mask);
        end else begin
          lw_read_data <= mem[address[5:0]];
        end
      end
    end
  end

  // observation results of one transaction (cycle 0 = grant cycle)
  int          en_first, en_last, en_cnt, f_cyc, f_cnt, l_cyc, l_cnt;
  logic        unstable, we_seen, bm_seen;
  logic [18:0] a_seen;
  logic [63:0] m_seen, d_seen, l_data;
  logic [511:0] f_data;

  task automatic observe(input int n, input int flush_at);
    en_first = -1; en_last = -1; en_cnt = 0; f_cyc = -1; f_cnt = 0; l_cyc = -1; l_cnt = 0;
    unstable = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin fetch_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      fetch_flush = (c == flush_at);
      @(negedge clk);
      if (chip_enable) begin
        if (en_first < 0) begin
          en_first = c; a_seen = address; we_seen = write_enable; bm_seen = burst_mode;
          m_seen = sw_write_mask; d_seen = sw_write_data;
        end else if (address !== a_seen || write_enable !== we_seen || burst_mode !== bm_seen) begin
          unstable = 1'b1;
        end
        en_last = c; en_cnt++;
      end
      if (fetch_resp_valid) begin f_cyc = c; f_cnt++; f_data = fetch_resp_data; end
      if (lsu_resp_valid) begin l_cyc = c; l_cnt++; l_data = lsu_resp_data; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({chip_enable, write_enable, burst_mode, fetch_resp_valid, lsu_resp_valid, ddr_timeout_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {chip_enable, write_enable, burst_mode, fetch_resp_valid, lsu_resp_valid, ddr_timeout_err}); end
    checks++; if (address !== 19'h0 || sw_write_mask !== 64'h0 || sw_write_data !== 64'h0) begin
      errors++; $display("FAIL reset_bus got addr %h mask %h data %h want 0", address, sw_write_mask, sw_write_data); end
    checks++; if ({fetch_req_ready, lsu_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready got %b want 00", {fetch_req_ready, lsu_req_ready}); end
  endtask

  task automatic test_lsu_read();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 64'h8000_0040; #1;
    checks++; if ({lsu_req_ready, fetch_req_ready} !== 2'b10) begin
      errors++; $display("FAIL rd_ready got %b want 10", {lsu_req_ready, fetch_req_ready}); end
    observe(72, 0);
    checks++; if (en_first !== 1 || en_last !== 65 || en_cnt !== 65) begin
      errors++; $display("FAIL rd_enable got %0d..%0d n=%0d want 1..65 n=65", en_first, en_last, en_cnt); end
    checks++; if (a_seen !== 19'h00008 || we_seen !== 1'b0 || bm_seen !== 1'b0) begin
      errors++; $display("FAIL rd_cmd got addr %h we %b bm %b want 00008 0 0", a_seen, we_seen, bm_seen); end
    checks++; if (l_cyc !== 67 || l_cnt !== 1 || f_cnt !== 0) begin
      errors++; $display("FAIL rd_resp_timing got cyc %0d n %0d fn %0d want 67 1 0", l_cyc, l_cnt, f_cnt); end
    checks++; if (l_data !== 64'h1234) begin
      errors++; $display("FAIL rd_data got %h want 1234", l_data); end
  endtask

  task automatic test_fetch_burst();
    logic [511:0] exp;
    for (int i = 0; i < 8; i++) exp[i*64 +: 64] = init_word(8 + i);
    @(negedge clk);
    fetch_req_valid = 1'b1; fetch_req_addr = 64'h8000_0047; #1;
    checks++; if ({lsu_req_ready, fetch_req_ready} !== 2'b01) begin
      errors++; $display("FAIL fe_ready got %b want 01", {lsu_req_ready, fetch_req_ready}); end
    observe(88, 0);
    checks++; if (en_first !== 1 || en_last !== 81 || en_cnt !== 81 || unstable !== 1'b0) begin
      errors++; $display("FAIL fe_enable got %0d..%0d n=%0d unstable %b want 1..81 n=81 0", en_first, en_last, en_cnt, unstable); end
    checks++; if (a_seen !== 19'h00008 || bm_seen !== 1'b1 || we_seen !== 1'b0) begin
      errors++; $display("FAIL fe_cmd got addr %h bm %b we %b want 00008 1 0", a_seen, bm_seen, we_seen); end
    checks++; if (f_cyc !== 83 || f_cnt !== 1 || l_cnt !== 0) begin
      errors++; $display("FAIL fe_resp_timing got cyc %0d n %0d ln %0d want 83 1 0", f_cyc, f_cnt, l_cnt); end
    checks++; if (f_data !== exp) begin
      errors++; $display("FAIL fe_data got %h want %h", f_data[127:0], exp[127:0]); end
  endtask

  task automatic test_lsu_write();
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 64'h8000_0080;
    lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wmask = 64'hFFFF_FFFF; #1;
    checks++; if (lsu_req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_ready got %b want 1", lsu_req_ready); end
    observe(72, 0);
    checks++; if (we_seen !== 1'b1 || bm_seen !== 1'b0 || a_seen !== 19'h00010) begin
      errors++; $display("FAIL wr_cmd got we %b bm %b addr %h want 1 0 00010", we_seen, bm_seen, a_seen); end
    checks++; if (m_seen !== 64'hFFFF_FFFF || d_seen !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_bus got mask %h data %h want ffffffff deadbeef", m_seen, d_seen); end
    checks++; if (l_cyc !== 67 || l_cnt !== 1 || l_data !== 64'h0) begin
      errors++; $display("FAIL wr_ack got cyc %0d n %0d data %h want 67 1 0", l_cyc, l_cnt, l_data); end
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; #1;
    observe(72, 0);
    checks++; if (l_data !== 64'h0000_0000_DEAD_BEEF || l_cnt !== 1) begin
      errors++; $display("FAIL wr_readback got %h n %0d want 00000000deadbeef 1", l_data, l_cnt); end
  endtask

  task automatic test_round_robin();
    int gn;
    int gc [3];
    logic gl [3];
    logic dbl;
    gn = 0; dbl = 1'b0;
    for (int i = 0; i < 3; i++) begin gc[i] = -1; gl[i] = 1'b0; end
    @(negedge clk); rst = 1'b1; #2 rst = 1'b0;
    fetch_req_valid = 1'b1; fetch_req_addr = 64'h8000_0040;
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 64'h8000_0040; #1;
    if (fetch_req_ready || lsu_req_ready) begin gc[0] = 0; gl[0] = lsu_req_ready; gn = 1; end
    for (int c = 1; c <= 230; c++) begin
      @(posedge clk); #1;
      if (gn >= 3) begin fetch_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      @(negedge clk);
      if (fetch_req_ready && lsu_req_ready) dbl = 1'b1;
      if (gn < 3 && (fetch_req_ready || lsu_req_ready)) begin gc[gn] = c; gl[gn] = lsu_req_ready; gn++; end
    end
    checks++; if (gc[0] !== 0 || gl[0] !== 1'b1) begin
      errors++; $display("FAIL rr_first got cyc %0d lsu %b want 0 1", gc[0], gl[0]); end
    checks++; if (gc[1] !== 67 || gl[1] !== 1'b0) begin
      errors++; $display("FAIL rr_second got cyc %0d lsu %b want 67 0", gc[1], gl[1]); end
    checks++; if (gc[2] !== 150 || gl[2] !== 1'b1) begin
      errors++; $display("FAIL rr_third got cyc %0d lsu %b want 150 1", gc[2], gl[2]); end
    checks++; if (dbl !== 1'b0) begin
      errors++; $display("FAIL rr_onehot got both-ready %b want 0", dbl); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    fetch_req_valid = 1'b1; fetch_flush = 1'b1; fetch_req_addr = 64'h8000_0100; #1;
    checks++; if (fetch_req_ready !== 1'b0) begin
      errors++; $display("FAIL flush_idle_ready got %b want 0", fetch_req_ready); end
    @(posedge clk); #1;
    checks++; if (chip_enable !== 1'b0) begin
      errors++; $display("FAIL flush_idle_accept got ce %b want 0", chip_enable); end
    fetch_flush = 1'b0; #1;
    observe(90, 40);
    checks++; if (en_last !== 81 || en_cnt !== 81) begin
      errors++; $display("FAIL flush_enable got last %0d n %0d want 81 81", en_last, en_cnt); end
    checks++; if (f_cnt !== 0) begin
      errors++; $display("FAIL flush_suppress got pulses %0d want 0", f_cnt); end
    @(negedge clk);
    fetch_req_valid = 1'b1; fetch_req_addr = 64'h8000_0040; #1;
    checks++; if (fetch_req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_next_ready got %b want 1", fetch_req_ready); end
    observe(90, 0);
    checks++; if (f_cnt !== 1 || f_cyc !== 83 || f_data[63:0] !== 64'h1234) begin
      errors++; $display("FAIL flush_next_resp got n %0d cyc %0d w0 %h want 1 83 1234", f_cnt, f_cyc, f_data[63:0]); end
  endtask

  task automatic test_timeout();
    int err_first;
    logic ce15;
    err_first = -1; ce15 = 1'b0;
    @(negedge clk);
    checks++; if (t_err !== 1'b0) begin
      errors++; $display("FAIL to_reset got %b want 0", t_err); end
    t_lsu_valid = 1'b1; #1;
    checks++; if (t_lsu_ready !== 1'b1) begin
      errors++; $display("FAIL to_ready got %b want 1", t_lsu_ready); end
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) t_lsu_valid = 1'b0;
      @(negedge clk);
      if (t_err && err_first < 0) err_first = c;
      if (c == 15) ce15 = t_ce;
    end
    checks++; if (err_first !== 11) begin
      errors++; $display("FAIL to_rise got cycle %0d want 11", err_first); end
    checks++; if (t_err !== 1'b1 || t_ce !== 1'b1 || ce15 !== 1'b1) begin
      errors++; $display("FAIL to_sticky got err %b ce %b ce15 %b want 1 1 1", t_err, t_ce, ce15); end
    #2 t_rst = 1'b1; #1;
    checks++; if (t_err !== 1'b0 || t_ce !== 1'b0) begin
      errors++; $display("FAIL to_async_rst got err %b ce %b want 0 0", t_err, t_ce); end
    @(posedge clk); #1 t_rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; t_rst = 1'b1;
    fetch_req_valid = 1'b0; fetch_req_addr = '0; fetch_flush = 1'b0;
    lsu_req_valid = 1'b0; lsu_req_we = 1'b0; lsu_req_addr = '0;
    lsu_req_wdata = '0; lsu_req_wmask = '0; t_lsu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; t_rst = 1'b0;
    test_reset();
    test_lsu_read();
    test_fetch_burst();
    test_lsu_write();
    test_round_robin();
    test_flush();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_arbiter.md
Name: ddr_arbiter

Overview:
Initiator side of the simulated-DDR interface: the block that drives chip_enable/write_enable/burst_mode/address and consumes ddr_operation_done and read data. Arbitrates between the frontend fetch port (512-bit burst read) and the LSU port (64-bit read or masked write). Holds one transaction at a time stable on the memory interface and returns responses with single-cycle valid pulses.

Parameters:
TIMEOUT, 255, cycles in BUSY without ddr_operation_done before ddr_timeout_err sets (sticky)
ADDR_LSB, 3, byte-address bit mapped to ddr address[0] (64-bit words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fetch_req_valid  in  1  fetch burst-read request
fetch_req_ready  out  1  fetch request accepted this cycle
fetch_req_addr  in  64  byte address; bits [5:0] ignored (forced 0)
fetch_flush  in  1  discard pending or in-flight fetch response
fetch_resp_valid  out  1  one-cycle pulse: fetch_resp_data valid
fetch_resp_data  out  512  burst read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_we  in  1  1 = write, 0 = read
lsu_req_addr  in  64  byte address; bits [2:0] ignored
lsu_req_wdata  in  64  write data
lsu_req_wmask  in  64  bit-granular write mask
lsu_resp_valid  out  1  one-cycle pulse: read data / write ack
lsu_resp_data  out  64  read data (0 on write ack)
chip_enable  out  1  to memory
write_enable  out  1  to memory
burst_mode  out  1  to memory
address  out  19  word index = addr[ADDR_LSB+18:ADDR_LSB]
sw_write_mask  out  64  to memory
sw_write_data  out  64  to memory
fetch_burst_read_inst  in  512  from memory
lw_read_data  in  64  from memory
ddr_operation_done  in  1  from memory, one-cycle completion pulse
ddr_timeout_err  out  1  sticky error flag

Behaviour:
- Reset: state IDLE, all outputs 0, rr_last=0 (last served = fetch), timeout counter 0, flush_pending 0.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE: grant when a request is valid. Both valid: alternate using rr_last (last fetch -> LSU wins, and vice versa). Exactly one *_req_ready is high in the grant cycle, combinationally. Only one valid: it wins. Accept edge registers we/burst/address/wmask/wdata/owner, updates rr_last, goes BUSY.
- BUSY: chip_enable = (state==BUSY) & ~ddr_operation_done. This is combinational, so the memory never sees enable in its idle cycle after completion and no second operation starts. write_enable, burst_mode, address, mask and data stay stable for the whole of BUSY. The memory samples address only at completion.
- Fetch: burst_mode=1, write_enable=0. LSU: burst_mode=0, write_enable=lsu_req_we.
- On ddr_operation_done in BUSY: capture fetch_burst_read_inst or lw_read_data into the response register; go RESP.
- RESP: one cycle; pulse owner's *_resp_valid; then IDLE. Write ack gives lsu_resp_data=0.
- Latency, accept edge = end of cycle 0: chip_enable high cycles 1..65 (single) or 1..81 (burst); done in cycle 66/82; resp_valid in cycle 67/83. Next grant possible in cycle 67/83 (IDLE reached after RESP); chip_enable in cycle 68/84.
- fetch_flush while owner=fetch in BUSY or RESP: memory op is never aborted (runs to completion). Set flush_pending; suppress fetch_resp_valid; clear flush_pending on return to IDLE. fetch_flush in IDLE with fetch_req_valid: request is not accepted that cycle.
- Timeout counter: increments in BUSY, clears on entering BUSY. At TIMEOUT, set ddr_timeout_err (sticky until rst); state stays BUSY.
- Reset mid-operation: state and chip_enable drop asynchronously. The memory is reset by the same top-level reset (inverted), so no operation is orphaned.

Decomposition:
- Shared package ddr_pkg: state enum (IDLE/BUSY/RESP); constants DDR_ADDR_W=19, DDR_BURST_W=512, DDR_WORD_W=64, SINGLE_LAT=64, BURST_LAT=80.
- One sub-module is natural: ddr_rr_arb, the 2-requester round-robin grant with rr_last. Everything else is inline.

Test Plan:
- LSU read at 0x80000040 (memory word 0x1234) -> chip_enable high exactly cycles 1..65, address=0x00008; lsu_resp_valid cycle 67, data=0x1234.
- Fetch at 0x80000047 -> address=0x00008, burst_mode=1, chip_enable 81 cycles; fetch_resp_valid cycle 83 with all 8 words.
- LSU write data 0xDEADBEEF, mask 0xFFFFFFFF -> write_enable=1; ack pulse with data 0; subsequent read returns 0x00000000DEADBEEF.
- Fetch and LSU valid together from reset -> LSU served first, then fetch; with both held, grants alternate LSU/fetch/LSU.
- fetch_flush in cycle 40 of a burst -> chip_enable still ends at cycle 81; no fetch_resp_valid; next request is accepted normally.
- Stub memory never sends done, TIMEOUT=10 -> ddr_timeout_err rises after 10 BUSY cycles and stays high; rst clears it and chip_enable.
